fetch_unit: RTL



---
 rtl/core_pkg.sv | 26 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: branch opcodes, fetch FSM states and the
// architectural NOP used to fill empty pipeline slots.
package core_pkg;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_EQ,
    BR_NE,
    BR_LT,
    BR_GE,
    BR_LTU,
    BR_GEU,
    BR_JAL
  } br_op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] RESET_NOP_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage between the branch unit and decode.
// Optional misaligned-PC fault handling is enabled by FETCH_MISALIGN_CHK_EN.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_NOP = RESET_NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        fetch_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        decode_ready,
  output logic        fetch_fault
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [31:0] r_req_addr;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        w_misalign;
  logic [31:0] w_addr;
  logic        w_rsp_match;

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_misalign = (pc[1:0] != 2'b00);
  assign w_addr     = pc;
`else
  assign w_misalign = 1'b0;
  assign w_addr     = {pc[31:2], 2'b00};
`endif

  assign w_rsp_match = (r_req_addr == pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (w_misalign) begin
          w_state_nxt = HOLD;
        end else if (imem_req_ready) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A response for a stale PC is dropped and the live PC refetched.
        if (imem_rsp_valid) begin
          w_state_nxt = w_rsp_match ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (decode_ready) begin
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath registers carry no reset; every use is qualified by r_state.
  always_ff @(posedge clk) begin
    if (r_state == REQ && w_misalign) begin
      r_instr    <= RESET_NOP;
      r_instr_pc <= pc;
    end else if (r_state == REQ && imem_req_ready) begin
      r_req_addr <= pc;
    end else if (r_state == WAIT && imem_rsp_valid && w_rsp_match) begin
      r_instr    <= imem_rsp_data;
      r_instr_pc <= r_req_addr;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (r_state == REQ && w_misalign) begin
      r_fault <= 1'b1;
    end else if (r_state == HOLD && decode_ready) begin
      r_fault <= 1'b0;
    end
  end

  assign fetch_fault = r_fault;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_req_valid = (r_state == REQ) && !w_misalign;
  assign imem_req_addr  = imem_req_valid ? w_addr : 32'h0000_0000;
  assign instr_valid    = (r_state == HOLD);
  assign instr          = instr_valid ? r_instr : RESET_NOP;
  assign instr_pc       = instr_valid ? r_instr_pc : 32'h0000_0000;
  assign fetch_stall    = !((r_state == HOLD) && decode_ready);

endmodule
